dsp_wresp_channel: RTL and testbench

Master-side write-response dispatcher of the AXI4 interconnect. It is the return path for transactions issued by the write-address dispatcher.
- Records the slave ID of every accepted AW in an in-order FIFO.
- Selects the B channel of the slave at the FIFO head, registers the response and returns it to the master in issue order.
- Back-pressures the write-address dispatcher when its outstanding capacity is exhausted.

---
 rtl/dsp_wresp_channel_pkg.sv | 16 +
 rtl/dsp_wresp_channel_if.sv | 36 +++
 rtl/dsp_wresp_channel_sync_fifo.sv | 60 ++++++
 rtl/dsp_wresp_channel.sv | 116 +++++++++++
 tb/tb_dsp_wresp_channel.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/dsp_wresp_channel_pkg.sv
// Shared AXI interconnect definitions: BRESP encodings and default widths.
package axi_icn_pkg;

   localparam int AXI_SLV_AMT_DEF   = 2;
   localparam int AXI_OUTST_DEF     = 8;
   localparam int AXI_MST_ID_W_DEF  = 5;
   localparam int AXI_WR_RESP_W_DEF = 2;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } bresp_e;

endpackage

// File: rtl/dsp_wresp_channel_if.sv
// Write-response dispatcher bus: AW order push, per-slave B channels, master B channel.
interface dsp_wresp_channel_if
   import axi_icn_pkg::*;
#(
   parameter int SLV_AMT         = AXI_SLV_AMT_DEF,
   parameter int TRANS_MST_ID_W  = AXI_MST_ID_W_DEF,
   parameter int TRANS_WR_RESP_W = AXI_WR_RESP_W_DEF,
   parameter int SLV_ID_W        = $clog2(SLV_AMT)
);
   logic [SLV_ID_W-1:0]                dsp_WADDR_slv_id_i;
   logic                               dsp_WADDR_shift_en_i;
   logic                               dsp_WADDR_outst_full_o;
   logic [TRANS_MST_ID_W*SLV_AMT-1:0]  sa_BID_i;
   logic [TRANS_WR_RESP_W*SLV_AMT-1:0] sa_BRESP_i;
   logic [SLV_AMT-1:0]                 sa_BVALID_i;
   logic [SLV_AMT-1:0]                 sa_BREADY_o;
   logic [TRANS_MST_ID_W-1:0]          m_BID_o;
   logic [TRANS_WR_RESP_W-1:0]         m_BRESP_o;
   logic                               m_BVALID_o;
   logic                               m_BREADY_i;
   logic                               dsp_err_o;

   modport slave (
      input  dsp_WADDR_slv_id_i, dsp_WADDR_shift_en_i, sa_BID_i, sa_BRESP_i,
             sa_BVALID_i, m_BREADY_i,
      output dsp_WADDR_outst_full_o, sa_BREADY_o, m_BID_o, m_BRESP_o,
             m_BVALID_o, dsp_err_o
   );

   modport master (
      output dsp_WADDR_slv_id_i, dsp_WADDR_shift_en_i, sa_BID_i, sa_BRESP_i,
             sa_BVALID_i, m_BREADY_i,
      input  dsp_WADDR_outst_full_o, sa_BREADY_o, m_BID_o, m_BRESP_o,
             m_BVALID_o, dsp_err_o
   );
endinterface

// File: rtl/dsp_wresp_channel_sync_fifo.sv
// Synchronous in-order FIFO with registered count and full flag; DEPTH must be a power of two.
module sync_fifo
   import axi_icn_pkg::*;
#(
   parameter int DATA_W = 1,
   parameter int DEPTH  = AXI_OUTST_DEF,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [CNT_W-1:0]  count_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, full_d;
   logic              push_acc_s, pop_acc_s;

   // A push into a full FIFO is only taken when an entry leaves in the same cycle.
   always_comb begin
      pop_acc_s  = pop_i && (count_q != {CNT_W{1'b0}});
      push_acc_s = push_i && (!full_q || pop_acc_s);
      wr_ptr_d   = push_acc_s ? wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1} : wr_ptr_q;
      rd_ptr_d   = pop_acc_s  ? rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1} : rd_ptr_q;
      count_d    = count_q + CNT_W'(push_acc_s) - CNT_W'(pop_acc_s);
      full_d     = (count_d == CNT_W'(DEPTH));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_acc_s) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = (count_q == {CNT_W{1'b0}});
   assign count_o = count_q;
endmodule

// File: rtl/dsp_wresp_channel.sv
// Master-side write-response dispatcher: returns slave B responses in AW issue order.
// Optional sticky protocol checking is built when DSP_WRESP_ERR_CHECK_EN is defined.
module dsp_wresp_channel
   import axi_icn_pkg::*;
#(
   parameter int SLV_AMT         = AXI_SLV_AMT_DEF,
   parameter int OUTSTANDING_AMT = AXI_OUTST_DEF,
   parameter int TRANS_MST_ID_W  = AXI_MST_ID_W_DEF,
   parameter int TRANS_WR_RESP_W = AXI_WR_RESP_W_DEF,
   parameter int SLV_ID_W        = $clog2(SLV_AMT),
   localparam int CNT_W          = $clog2(OUTSTANDING_AMT) + 1
) (
   input  logic                ACLK_i,
   input  logic                ARESET_i,
   dsp_wresp_channel_if.slave  bus_io
);
   logic [SLV_ID_W-1:0]        fifo_head_s;
   logic                       fifo_full_s, fifo_empty_s;
   logic [CNT_W-1:0]           fifo_count_s;
   logic                       out_free_s, capture_s;
   logic [SLV_AMT-1:0]         bready_s;
   logic [TRANS_MST_ID_W-1:0]  sel_bid_s, m_bid_q, m_bid_d;
   logic [TRANS_WR_RESP_W-1:0] sel_bresp_s, m_bresp_q, m_bresp_d;
   logic                       m_bvalid_q, m_bvalid_d;

   sync_fifo #(
      .DATA_W (SLV_ID_W),
      .DEPTH  (OUTSTANDING_AMT)
   ) u_order_fifo (
      .clk_i   (ACLK_i),
      .rst_i   (ARESET_i),
      .push_i  (bus_io.dsp_WADDR_shift_en_i),
      .pop_i   (capture_s),
      .data_i  (bus_io.dsp_WADDR_slv_id_i),
      .data_o  (fifo_head_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s)
   );

   // Only the slave at the FIFO head is readied; a head ID beyond SLV_AMT matches nothing.
   always_comb begin
      out_free_s  = !m_bvalid_q || bus_io.m_BREADY_i;
      bready_s    = {SLV_AMT{1'b0}};
      sel_bid_s   = {TRANS_MST_ID_W{1'b0}};
      sel_bresp_s = {TRANS_WR_RESP_W{1'b0}};
      for (int k = 0; k < SLV_AMT; k++) begin
         if (fifo_head_s == SLV_ID_W'(k)) begin
            bready_s[k] = !fifo_empty_s && out_free_s && (fifo_count_s != {CNT_W{1'b0}});
            sel_bid_s   = bus_io.sa_BID_i[k*TRANS_MST_ID_W +: TRANS_MST_ID_W];
            sel_bresp_s = bus_io.sa_BRESP_i[k*TRANS_WR_RESP_W +: TRANS_WR_RESP_W];
         end else begin
            bready_s[k] = 1'b0;
         end
      end
      capture_s = |(bus_io.sa_BVALID_i & bready_s);
   end

   // Output register: a capture takes priority over a drain so responses can stream.
   always_comb begin
      m_bvalid_d = m_bvalid_q;
      m_bid_d    = m_bid_q;
      m_bresp_d  = m_bresp_q;
      if (capture_s) begin
         m_bvalid_d = 1'b1;
         m_bid_d    = sel_bid_s;
         m_bresp_d  = sel_bresp_s;
      end else if (m_bvalid_q && bus_io.m_BREADY_i) begin
         m_bvalid_d = 1'b0;
      end else begin
         m_bvalid_d = m_bvalid_q;
      end
   end

   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         m_bvalid_q <= 1'b0;
         m_bid_q    <= {TRANS_MST_ID_W{1'b0}};
         m_bresp_q  <= TRANS_WR_RESP_W'(RESP_OKAY);
      end else begin
         m_bvalid_q <= m_bvalid_d;
         m_bid_q    <= m_bid_d;
         m_bresp_q  <= m_bresp_d;
      end
   end

   assign bus_io.sa_BREADY_o            = bready_s;
   assign bus_io.m_BVALID_o             = m_bvalid_q;
   assign bus_io.m_BID_o                = m_bid_q;
   assign bus_io.m_BRESP_o              = m_bresp_q;
   assign bus_io.dsp_WADDR_outst_full_o = fifo_full_s;

`ifdef DSP_WRESP_ERR_CHECK_EN
   logic err_q, err_d;

   // Sticky: overflow push, out-of-range slave ID, or a B response with nothing outstanding.
   always_comb begin
      err_d = err_q
            | (bus_io.dsp_WADDR_shift_en_i && fifo_full_s && !capture_s)
            | (bus_io.dsp_WADDR_shift_en_i && (int'(bus_io.dsp_WADDR_slv_id_i) >= SLV_AMT))
            | (fifo_empty_s && (|bus_io.sa_BVALID_i));
   end

   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus_io.dsp_err_o = err_q;
`else
   assign bus_io.dsp_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_dsp_wresp_channel.sv
// Directed bench for dsp_wresp_channel: ordering, throughput, back-pressure, full, reset.
module tb_dsp_wresp_channel;
   localparam int ID_W = 5;
   localparam int RS_W = 2;
`ifdef DSP_WRESP_ERR_CHECK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   dsp_wresp_channel_if #(.SLV_AMT(2), .TRANS_MST_ID_W(ID_W), .TRANS_WR_RESP_W(RS_W)) bus ();

   dsp_wresp_channel #(
      .SLV_AMT(2), .OUTSTANDING_AMT(8), .TRANS_MST_ID_W(ID_W), .TRANS_WR_RESP_W(RS_W)
   ) dut (
      .ACLK_i   (clk),
      .ARESET_i (rst),
      .bus_io   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic id);
      bus.dsp_WADDR_slv_id_i   = id;
      bus.dsp_WADDR_shift_en_i = 1'b1;
      tick();
      bus.dsp_WADDR_shift_en_i = 1'b0;
   endtask

   task automatic set_b(input int k, input logic v, input logic [ID_W-1:0] id, input logic [RS_W-1:0] rs);
      bus.sa_BVALID_i[k]              = v;
      bus.sa_BID_i[k*ID_W +: ID_W]    = id;
      bus.sa_BRESP_i[k*RS_W +: RS_W]  = rs;
   endtask

   task automatic check_resp(input string tag, input logic [ID_W-1:0] id, input logic [RS_W-1:0] rs);
      check_val({tag, "_valid"}, 32'(bus.m_BVALID_o), 32'd1);
      check_val({tag, "_bid"},   32'(bus.m_BID_o),    32'(id));
      check_val({tag, "_bresp"}, 32'(bus.m_BRESP_o),  32'(rs));
   endtask

   initial begin
      bus.dsp_WADDR_slv_id_i   = 1'b0;
      bus.dsp_WADDR_shift_en_i = 1'b0;
      bus.sa_BID_i             = '0;
      bus.sa_BRESP_i           = '0;
      bus.sa_BVALID_i          = '0;
      bus.m_BREADY_i           = 1'b0;
      tick();
      tick();
      check_val("rst_bvalid", 32'(bus.m_BVALID_o), 32'd0);
      check_val("rst_bid",    32'(bus.m_BID_o),    32'd0);
      check_val("rst_bresp",  32'(bus.m_BRESP_o),  32'd0);
      check_val("rst_bready", 32'(bus.sa_BREADY_o), 32'd0);
      check_val("rst_full",   32'(bus.dsp_WADDR_outst_full_o), 32'd0);
      check_val("rst_err",    32'(bus.dsp_err_o),  32'd0);
      rst = 1'b0;

      // In-order return: slave1 answers first but must wait for slave0.
      bus.m_BREADY_i = 1'b1;
      push(1'b0); push(1'b1); push(1'b0); push(1'b1);
      check_val("ord_count", 32'(dut.fifo_count_s), 32'd4);
      set_b(1, 1'b1, 5'd3, 2'd0);
      #1;
      check_val("ord_bready_head0", 32'(bus.sa_BREADY_o), 32'd1);
      tick();
      check_val("ord_no_early", 32'(bus.m_BVALID_o), 32'd0);
      set_b(0, 1'b1, 5'd4, 2'd1);
      tick();
      check_resp("ord_r0", 5'd4, 2'd1);
      set_b(0, 1'b0, 5'd0, 2'd0);
      #1;
      check_val("ord_bready_head1", 32'(bus.sa_BREADY_o), 32'd2);
      tick();
      check_resp("ord_r1", 5'd3, 2'd0);
      set_b(1, 1'b0, 5'd0, 2'd0);
      set_b(0, 1'b1, 5'd5, 2'd0);
      tick();
      check_resp("ord_r2", 5'd5, 2'd0);
      set_b(0, 1'b0, 5'd0, 2'd0);
      set_b(1, 1'b1, 5'd6, 2'd3);
      tick();
      check_resp("ord_r3", 5'd6, 2'd3);
      set_b(1, 1'b0, 5'd0, 2'd0);
      tick();
      check_val("ord_drained", 32'(bus.m_BVALID_o), 32'd0);
      check_val("ord_count_end", 32'(dut.fifo_count_s), 32'd0);

      // Throughput: one response per cycle with both slaves valid.
      push(1'b0); push(1'b1); push(1'b0); push(1'b1);
      set_b(0, 1'b1, 5'd7, 2'd0);
      set_b(1, 1'b1, 5'd8, 2'd3);
      tick(); check_resp("bb_r0", 5'd7, 2'd0);
      tick(); check_resp("bb_r1", 5'd8, 2'd3);
      tick(); check_resp("bb_r2", 5'd7, 2'd0);
      tick(); check_resp("bb_r3", 5'd8, 2'd3);
      check_val("bb_count", 32'(dut.fifo_count_s), 32'd0);
      check_val("bb_bready", 32'(bus.sa_BREADY_o), 32'd0);
      set_b(0, 1'b0, 5'd0, 2'd0);
      set_b(1, 1'b0, 5'd0, 2'd0);
      tick();
      check_val("bb_drained", 32'(bus.m_BVALID_o), 32'd0);

      // Master back-pressure: response held, no slave readied.
      bus.m_BREADY_i = 1'b0;
      push(1'b0); push(1'b1);
      set_b(0, 1'b1, 5'd9, 2'b10);
      tick();
      check_resp("bp_cap", 5'd9, 2'b10);
      set_b(0, 1'b0, 5'd0, 2'd0);
      set_b(1, 1'b1, 5'd10, 2'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_resp("bp_hold", 5'd9, 2'b10);
         check_val("bp_bready", 32'(bus.sa_BREADY_o), 32'd0);
         check_val("bp_count", 32'(dut.fifo_count_s), 32'd1);
      end
      bus.m_BREADY_i = 1'b1;
      #1;
      check_val("bp_release_bready", 32'(bus.sa_BREADY_o), 32'd2);
      tick();
      check_resp("bp_next", 5'd10, 2'd1);
      set_b(1, 1'b0, 5'd0, 2'd0);
      tick();
      check_val("bp_drained", 32'(bus.m_BVALID_o), 32'd0);

      // Capacity: full after 8, 9th ignored, push+pop at full keeps 8.
      for (int i = 0; i < 7; i++) push(1'b0);
      check_val("full_at7", 32'(bus.dsp_WADDR_outst_full_o), 32'd0);
      push(1'b0);
      check_val("full_at8", 32'(bus.dsp_WADDR_outst_full_o), 32'd1);
      check_val("full_count8", 32'(dut.fifo_count_s), 32'd8);
      push(1'b0);
      check_val("ovf_count", 32'(dut.fifo_count_s), 32'd8);
      check_val("ovf_err", 32'(bus.dsp_err_o), 32'(ERR_EXP));
      set_b(0, 1'b1, 5'd12, 2'd0);
      push(1'b0);
      check_val("pp_count", 32'(dut.fifo_count_s), 32'd8);
      check_val("pp_full", 32'(bus.dsp_WADDR_outst_full_o), 32'd1);
      check_resp("pp_resp", 5'd12, 2'd0);
      for (int i = 0; i < 5; i++) tick();
      check_val("pop5_count", 32'(dut.fifo_count_s), 32'd3);
      check_val("pop5_full", 32'(bus.dsp_WADDR_outst_full_o), 32'd0);
      check_val("pop5_valid", 32'(bus.m_BVALID_o), 32'd1);

      // Asynchronous reset mid-stream.
      rst = 1'b1;
      #1;
      check_val("ar_bvalid", 32'(bus.m_BVALID_o), 32'd0);
      check_val("ar_bid",    32'(bus.m_BID_o),    32'd0);
      check_val("ar_bready", 32'(bus.sa_BREADY_o), 32'd0);
      check_val("ar_count",  32'(dut.fifo_count_s), 32'd0);
      check_val("ar_err",    32'(bus.dsp_err_o),  32'd0);
      set_b(0, 1'b0, 5'd0, 2'd0);
      tick();
      rst = 1'b0;
      push(1'b1);
      set_b(1, 1'b1, 5'd11, 2'd3);
      tick();
      check_resp("ar_after", 5'd11, 2'd3);
      check_val("ar_after_count", 32'(dut.fifo_count_s), 32'd0);
      set_b(1, 1'b0, 5'd0, 2'd0);
      tick();
      check_val("ar_after_drain", 32'(bus.m_BVALID_o), 32'd0);

      // Orphan BVALID with empty FIFO.
      set_b(0, 1'b1, 5'd1, 2'd0);
      #1;
      check_val("orph_bready", 32'(bus.sa_BREADY_o), 32'd0);
      tick();
      check_val("orph_err", 32'(bus.dsp_err_o), 32'(ERR_EXP));
      check_val("orph_valid", 32'(bus.m_BVALID_o), 32'd0);
      set_b(0, 1'b0, 5'd0, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
